// File: rtl/instr_sequencer.sv
// Instruction sequencer for the 10-bit processor: owns IR and timestep counter T,
// starts one instruction per synchronised Execute press and watches for a missing Clr.
module instr_sequencer #(
    parameter int unsigned IW          = 10,
    parameter int unsigned TW          = 2,
    parameter int unsigned MAX_T       = 3,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CW          = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          exec_btn,
    input  logic [IW-1:0] data_in,
    input  logic          clr_in,
    input  logic          fault_ack,
    output logic [IW-1:0] ir,
    output logic [TW-1:0] T,
    output logic          busy,
    output logic          done,
    output logic          fault,
    output logic [CW-1:0] retired
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_synced;
    logic                   w_start;
    logic                   w_t_last;

    logic [IW-1:0]          r_ir;
    logic [TW-1:0]          r_t;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_fault;
    logic [CW-1:0]          r_retired;

    logic [IW-1:0]          w_ir_nxt;
    logic [TW-1:0]          w_t_nxt;
    logic                   w_busy_nxt;
    logic                   w_done_nxt;
    logic                   w_fault_nxt;
    logic [CW-1:0]          w_retired_nxt;

    // Button synchroniser and rising-edge detector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], exec_btn};
            r_prev <= w_synced;
        end
    end

    assign w_synced = r_sync[SYNC_STAGES-1];
    assign w_start  = w_synced & ~r_prev;
    assign w_t_last = (r_t == TW'(MAX_T));

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ir      <= '0;
            r_t       <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_fault   <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ir      <= w_ir_nxt;
            r_t       <= w_t_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_fault   <= w_fault_nxt;
            r_retired <= w_retired_nxt;
        end
    end

    // Next-state logic; Clr has priority over the watchdog at T==MAX_T
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_start) w_state_nxt = ST_EXEC;
            ST_EXEC: begin
                if (clr_in)        w_state_nxt = ST_IDLE;
                else if (w_t_last) w_state_nxt = ST_FAULT;
            end
            ST_FAULT: if (fault_ack) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        w_ir_nxt      = r_ir;
        w_t_nxt       = r_t;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_fault_nxt   = r_fault;
        w_retired_nxt = r_retired;
        case (r_state)
            ST_IDLE: begin
                w_t_nxt = '0;
                if (w_start) begin
                    w_ir_nxt   = data_in;
                    w_busy_nxt = 1'b1;
                end
            end
            ST_EXEC: begin
                if (clr_in) begin
                    w_t_nxt       = '0;
                    w_busy_nxt    = 1'b0;
                    w_done_nxt    = 1'b1;
                    w_retired_nxt = r_retired + CW'(1);
                end else if (w_t_last) begin
                    w_t_nxt     = '0;
                    w_busy_nxt  = 1'b0;
                    w_fault_nxt = 1'b1;
                end else begin
                    w_t_nxt = r_t + TW'(1);
                end
            end
            ST_FAULT: if (fault_ack) w_fault_nxt = 1'b0;
            default: begin
                w_t_nxt     = '0;
                w_busy_nxt  = 1'b0;
                w_fault_nxt = 1'b0;
            end
        endcase
    end

    assign ir      = r_ir;
    assign T       = r_t;
    assign busy    = r_busy;
    assign done    = r_done;
    assign fault   = r_fault;
    assign retired = r_retired;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus random stimulus,
// all checked every cycle against a behavioural model of the sequencer.
module tb_instr_sequencer;

    localparam int unsigned IW    = 10;
    localparam int unsigned TW    = 2;
    localparam int unsigned MAX_T = 3;
    localparam int unsigned SS    = 2;
    localparam int unsigned CW    = 8;

    localparam int M_IDLE  = 0;
    localparam int M_EXEC  = 1;
    localparam int M_FAULT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          exec_btn;
    logic [IW-1:0] data_in;
    logic          clr_in;
    logic          fault_ack;
    logic [IW-1:0] ir;
    logic [TW-1:0] T;
    logic          busy;
    logic          done;
    logic          fault;
    logic [CW-1:0] retired;

    instr_sequencer #(
        .IW(IW), .TW(TW), .MAX_T(MAX_T), .SYNC_STAGES(SS), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .exec_btn(exec_btn), .data_in(data_in),
        .clr_in(clr_in), .fault_ack(fault_ack), .ir(ir), .T(T),
        .busy(busy), .done(done), .fault(fault), .retired(retired)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model: instruction phase, step count, and button sample history
    int            m_mode;
    logic [IW-1:0] m_ir;
    int            m_t;
    bit            m_busy, m_done, m_fault;
    int            m_ret;
    bit            hist[$];

    function automatic bit hist_at(int i);
        return (i < hist.size()) ? hist[i] : 1'b0;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_ir = '0; m_t = 0;
        m_busy = 0; m_done = 0; m_fault = 0; m_ret = 0;
        hist.delete();
    endtask

    task automatic model_edge();
        bit st;
        hist.push_front(exec_btn);
        if (hist.size() > SS + 2) void'(hist.pop_back());
        // a press is seen SS edges after it is first sampled, once per rising level
        st = hist_at(SS) && !hist_at(SS + 1);
        m_done = 0;
        case (m_mode)
            M_IDLE: begin
                m_t = 0;
                if (st) begin
                    m_mode = M_EXEC; m_ir = data_in; m_busy = 1;
                end
            end
            M_EXEC: begin
                if (clr_in) begin
                    m_mode = M_IDLE; m_t = 0; m_busy = 0; m_done = 1;
                    m_ret  = (m_ret + 1) % (1 << CW);
                end else if (m_t == MAX_T) begin
                    m_mode = M_FAULT; m_t = 0; m_busy = 0; m_fault = 1;
                end else begin
                    m_t = m_t + 1;
                end
            end
            default: begin
                if (fault_ack) begin
                    m_mode = M_IDLE; m_fault = 0;
                end
            end
        endcase
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ir",      32'(ir),      32'(m_ir));
        chk("T",       32'(T),       32'(m_t));
        chk("busy",    32'(busy),    32'(m_busy));
        chk("done",    32'(done),    32'(m_done));
        chk("fault",   32'(fault),   32'(m_fault));
        chk("retired", 32'(retired), 32'(m_ret));
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
        check_all();
    endtask

    task automatic cycles(int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    // One press, then Clr at step clr_at (clr_at > MAX_T never clears)
    task automatic run_instr(input logic [IW-1:0] d, input int clr_at, output int bc);
        data_in  = d;
        clr_in   = 1'b0;
        exec_btn = 1'b1;
        cyc();
        exec_btn = 1'b0;
        for (int i = 0; i < 8 && !m_busy; i++) cyc();
        chk("start_seen", 32'(busy), 32'd1);
        bc = busy ? 1 : 0;
        for (int i = 0; i < 8 && m_busy; i++) begin
            clr_in = (m_t == clr_at);
            cyc();
            if (busy) bc++;
        end
        clr_in = 1'b0;
    endtask

    int bc;
    int r0;

    initial begin
        rst = 1'b1; exec_btn = 1'b0; data_in = '0; clr_in = 1'b0; fault_ack = 1'b0;
        model_reset();

        // 1: reset and idle
        cycles(3);
        rst = 1'b0;
        cycles(20);

        // 2: basic instruction, Clr at T==1
        run_instr(10'h062, 1, bc);
        chk("t2_ir", 32'(ir), 32'h062);
        chk("t2_busy_cycles", 32'(bc), 32'd2);
        chk("t2_retired", 32'(retired), 32'd1);
        cycles(2);

        // 3: watchdog fault, ignored press, acknowledge, normal run
        run_instr(IW'($urandom), 99, bc);
        chk("t3_fault", 32'(fault), 32'd1);
        chk("t3_busy_cycles", 32'(bc), 32'(MAX_T + 1));
        exec_btn = 1'b1; cyc(); exec_btn = 1'b0;
        cycles(5);
        chk("t3_press_ignored", 32'(busy), 32'd0);
        fault_ack = 1'b1; cyc(); fault_ack = 1'b0;
        chk("t3_ack", 32'(fault), 32'd0);
        r0 = m_ret;
        run_instr(IW'($urandom), 0, bc);
        chk("t3_after_ack", 32'(retired), 32'((r0 + 1) % 256));

        // 4: Clr on the same edge as T==MAX_T retires
        r0 = m_ret;
        run_instr(IW'($urandom), MAX_T, bc);
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_no_fault", 32'(fault), 32'd0);
        chk("t4_retired", 32'(retired), 32'((r0 + 1) % 256));

        // 5: button held across several Clr-ended windows starts only once
        r0 = m_ret;
        exec_btn = 1'b1;
        data_in  = IW'($urandom);
        for (int i = 0; i < 24; i++) begin
            clr_in = m_busy && (m_t == 1);
            cyc();
        end
        clr_in = 1'b0; exec_btn = 1'b0;
        cycles(3);
        chk("t5_one_start", 32'(retired), 32'((r0 + 1) % 256));
        run_instr(IW'($urandom), 1, bc);
        chk("t5_repress", 32'(retired), 32'((r0 + 2) % 256));

        // 6: counter wrap
        for (int i = 0; i < 300 && m_ret != 255; i++)
            run_instr(IW'($urandom), int'($urandom_range(MAX_T)), bc);
        chk("t6_pre_wrap", 32'(retired), 32'd255);
        run_instr(IW'($urandom), 2, bc);
        chk("t6_wrap", 32'(retired), 32'd0);

        // 6b: asynchronous reset while T==2
        data_in = IW'($urandom);
        exec_btn = 1'b1; cyc(); exec_btn = 1'b0;
        for (int i = 0; i < 8 && !(m_busy && m_t == 2); i++) cyc();
        chk("t6_pre_rst_T", 32'(T), 32'd2);
        rst = 1'b1;
        #1;
        model_reset();
        chk("t6_rst_T", 32'(T), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_done", 32'(done), 32'd0);
        check_all();
        cycles(2);
        rst = 1'b0;
        cycles(3);

        // random stimulus against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(3) == 0) exec_btn = ~exec_btn;
            clr_in    = ($urandom_range(2) == 0);
            fault_ack = ($urandom_range(3) == 0);
            data_in   = IW'($urandom);
            rst       = ($urandom_range(199) == 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
